// File: rtl/toggle_reg_bank.sv
// Bank of WIDTH toggle flip-flops with edge/level request decode, per-channel lockout,
// parallel load and change pulses. Define TOGGLE_REG_BANK_SYNC_EN to add a 2-flop input synchroniser.
module toggle_reg_bank #(
   parameter int              WIDTH     = 4,
   parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}},
   parameter bit              EDGE_MODE = 1'b1,
   parameter int              LOCKOUT   = 0,
   parameter int              CNT_W     = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             en,
   input  logic [WIDTH-1:0] t,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] changed,
   output logic [WIDTH-1:0] busy
);

   logic [WIDTH-1:0] t_int;
   logic [WIDTH-1:0] t_d_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] changed_reg;
   logic [WIDTH-1:0] req;
   logic [WIDTH-1:0] accept;

`ifdef TOGGLE_REG_BANK_SYNC_EN
   logic [WIDTH-1:0] sync1_reg;
   logic [WIDTH-1:0] sync2_reg;

   // Both stages preload the raw input during reset so release cannot fabricate an edge.
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         sync1_reg <= t;
         sync2_reg <= t;
      end else begin
         sync1_reg <= t;
         sync2_reg <= sync1_reg;
      end
   end

   assign t_int = sync2_reg;
`else
   assign t_int = t;
`endif

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         q_reg       <= INIT;
         changed_reg <= '0;
         t_d_reg     <= t;
      end else begin
         q_reg       <= q_next;
         changed_reg <= q_next ^ q_reg;
         t_d_reg     <= t_int;
      end
   end

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         assign req[gi]    = EDGE_MODE ? (t_int[gi] & ~t_d_reg[gi]) : t_int[gi];
         assign busy[gi]   = (cnt_reg != '0);
         // Load wins over toggles; a request that is not accepted is simply lost.
         assign accept[gi] = en & req[gi] & ~busy[gi] & ~load;

         assign q_next[gi] = load       ? load_data[gi] :
                             accept[gi] ? ~q_reg[gi]    : q_reg[gi];

         assign cnt_next   = load       ? '0                :
                             accept[gi] ? CNT_W'(LOCKOUT)   :
                             busy[gi]   ? cnt_reg - CNT_W'(1) : cnt_reg;

         always_ff @(posedge CLOCK) begin
            if (!RESET_N) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end
      end
   endgenerate

   assign q       = q_reg;
   assign changed = changed_reg;

endmodule
